// File: rtl/lcd_cmd_dispatcher.sv
// lcd_cmd_dispatcher: buffers host commands and issues them to the LCD controller when it is idle.
// Define LCD_DISP_STATS_EN to build the saturating issued_cnt counter.
module lcd_cmd_dispatcher #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       in_cmd,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [3:0]       cmd,
  output logic             cmd_valid,
  input  logic             busy,
  input  logic             done,
  output logic [CNT_W-1:0] fifo_count,
  output logic             seq_done,
  output logic [7:0]       issued_cnt
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, GUARD, WAIT_DONE, FIN} state_t;
  state_t state, state_nx;
  logic [3:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [3:0] head;
  logic push, pop, issue, flush, full, empty;
  assign full = fifo_count == CNT_W'(DEPTH);
  assign empty = fifo_count == '0;
  assign head = mem[rd_ptr];
  assign in_ready = !full && state != FIN;
  assign push = in_valid && in_ready;
  always_comb begin
    pop = state == IDLE && !empty && !busy;
    issue = pop && head < 4'd12;
    flush = state == WAIT_DONE && done;
    state_nx = state == GUARD ? IDLE : flush ? FIN : !issue ? state : head == 4'd0 ? WAIT_DONE : GUARD;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cmd <= '0;
      cmd_valid <= 1'b0;
      seq_done <= 1'b0;
    end else begin
      state <= state_nx;
      cmd_valid <= issue;
      if (issue) cmd <= head;
      if (flush) seq_done <= 1'b1;
    end
  end
  // Entering FIN drops whatever is still queued, including a push in the same cycle.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
    end
  end
  always_ff @(posedge clk) if (push) mem[wr_ptr] <= in_cmd;
`ifdef LCD_DISP_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) issued_cnt <= '0;
    else if (issue && issued_cnt != 8'hFF) issued_cnt <= issued_cnt + 8'd1;
  end
`else
  assign issued_cnt = '0;
`endif
endmodule

// File: tb/tb_lcd_cmd_dispatcher.sv
// tb_lcd_cmd_dispatcher: directed scenarios plus random traffic checked against a queue-based reference model.
module tb_lcd_cmd_dispatcher;
  localparam int DEPTH = 8;
  localparam int CNT_W = 4;
`ifdef LCD_DISP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, busy = 1'b0, done = 1'b0;
  logic [3:0] in_cmd = '0;
  logic in_ready, cmd_valid, seq_done;
  logic [3:0] cmd;
  logic [CNT_W-1:0] fifo_count;
  logic [7:0] issued_cnt;
  int checks = 0, failures = 0, cyc_n = 0;
  int q[$], seen[$], tm[$], exp_q[$];
  int m_cmd, m_iss;
  bit m_cv, m_seq, m_guard, m_wait, last_busy, prev_cv;

  lcd_cmd_dispatcher #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_cmd(in_cmd), .in_valid(in_valid), .in_ready(in_ready),
    .cmd(cmd), .cmd_valid(cmd_valid), .busy(busy), .done(done),
    .fifo_count(fifo_count), .seq_done(seq_done), .issued_cnt(issued_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc_n);
    end
  endtask

  // Reference: a command queue, one idle cycle after every non-terminal issue,
  // terminal code 0 freezes issue until done, then everything is flushed for good.
  task automatic model_step();
    bit rdy, go, fin;
    int c;
    last_busy = busy;
    if (reset) begin
      q.delete();
      m_cmd = 0; m_iss = 0; m_cv = 0; m_seq = 0; m_guard = 0; m_wait = 0;
      return;
    end
    rdy = q.size() < DEPTH && !m_seq;
    go = !m_guard && !m_wait && !m_seq && q.size() > 0 && !busy;
    fin = m_wait && done;
    m_cv = 0;
    m_guard = 0;
    if (go) begin
      c = q.pop_front();
      if (c < 12) begin
        m_cv = 1;
        m_cmd = c;
        m_guard = c != 0;
        m_wait = c == 0;
        if (m_iss < 255) m_iss++;
      end
    end
    if (in_valid && rdy) q.push_back(int'(in_cmd));
    if (fin) begin
      q.delete();
      m_seq = 1;
      m_wait = 0;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    cyc_n++;
    @(negedge clk);
    chk("cmd_valid", cmd_valid, m_cv);
    chk("cmd", cmd, m_cmd);
    chk("fifo_count", fifo_count, q.size());
    chk("in_ready", in_ready, q.size() < DEPTH && !m_seq);
    chk("seq_done", seq_done, m_seq);
    chk("issued_cnt", issued_cnt, STATS ? m_iss : 0);
    chk("back_to_back", cmd_valid && prev_cv, 0);
    chk("issue_while_busy", cmd_valid && last_busy, 0);
    prev_cv = cmd_valid;
    if (cmd_valid) begin
      seen.push_back(int'(cmd));
      tm.push_back(cyc_n);
    end
  endtask

  task automatic push(input int c);
    in_valid = 1'b1;
    in_cmd = 4'(c);
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; busy = 1'b0; done = 1'b0; in_valid = 1'b0;
    cyc();
    reset = 1'b0;
    seen.delete();
    tm.delete();
  endtask

  task automatic chk_seen(input string tag);
    chk({tag, "_n"}, seen.size(), exp_q.size());
    for (int i = 0; i < seen.size() && i < exp_q.size(); i++) chk(tag, seen[i], exp_q[i]);
  endtask

  initial begin
    do_reset();
    chk("rst_cmd", cmd, 0);
    chk("rst_count", fifo_count, 0);
    // Busy during image load: commands queue up, then issue two cycles apart.
    busy = 1'b1;
    for (int i = 0; i < 70; i++) cyc();
    push(1); push(4); push(5);
    cyc();
    chk("load_count", fifo_count, 3);
    chk("load_nostrobe", seen.size(), 0);
    busy = 1'b0;
    for (int i = 0; i < 10; i++) cyc();
    exp_q = '{1, 4, 5};
    chk_seen("load_order");
    if (tm.size() == 3) begin
      chk("load_gap1", tm[1] - tm[0], 2);
      chk("load_gap2", tm[2] - tm[1], 2);
    end
    chk("load_drained", fifo_count, 0);
    // Overfill: ninth push refused.
    do_reset();
    busy = 1'b1;
    for (int i = 0; i < 9; i++) begin
      chk("full_ready", in_ready, i < DEPTH);
      push(i + 1);
    end
    chk("full_count", fifo_count, DEPTH);
    // Discarded code never reaches cmd.
    do_reset();
    push(7); push(14); push(2);
    for (int i = 0; i < 8; i++) cyc();
    exp_q = '{7, 2};
    chk_seen("discard");
    chk("discard_stats", issued_cnt, STATS ? 2 : 0);
    // Terminal write then done.
    do_reset();
    push(3); push(0); push(6);
    for (int i = 0; i < 20 && !(seen.size() > 0 && seen[$] == 0); i++) cyc();
    chk("term_issued", seen.size() > 0 && seen[$] == 0, 1);
    busy = 1'b1;
    for (int i = 0; i < 64; i++) cyc();
    done = 1'b1;
    cyc();
    done = 1'b0;
    busy = 1'b0;
    for (int i = 0; i < 5; i++) cyc();
    exp_q = '{3, 0};
    chk_seen("term_order");
    chk("term_seq", seq_done, 1);
    chk("term_count", fifo_count, 0);
    chk("term_ready", in_ready, 0);
    // Reset in WAIT_DONE with two queued.
    do_reset();
    push(0); push(5); push(6);
    cyc();
    chk("wd_count", fifo_count, 2);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("wd_rst_count", fifo_count, 0);
    chk("wd_rst_seq", seq_done, 0);
    chk("wd_rst_cmd", cmd, 0);
    chk("wd_rst_cv", cmd_valid, 0);
    chk("wd_rst_ready", in_ready, 1);
    // Busy toggling every cycle.
    do_reset();
    busy = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(int'($urandom_range(1, 11)));
      push(exp_q[i]);
    end
    for (int i = 0; i < 30; i++) begin
      busy = ~busy;
      cyc();
    end
    chk_seen("toggle_order");
    // Random traffic.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = int'($urandom_range(0, 15));
      if (r == 0 && $urandom_range(0, 3) != 0) r = 1;
      in_valid = 1'($urandom_range(0, 1));
      in_cmd = 4'(r);
      busy = $urandom_range(0, 2) == 0;
      done = $urandom_range(0, 30) == 0;
      reset = $urandom_range(0, 150) == 0;
      cyc();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
